vga_mode_ctrl: RTL and testbench

Sequencer that owns the `mode` input of the VGA timing generator. It accepts mode-change requests from the host or config logic over a valid/ready handshake. Each change is applied exactly at a frame wrap, and video is then force-blanked for a programmable number of settle frames so the monitor can relock. It also produces frame/line event strobes and a frame counter for downstream pixel logic.

---
 rtl/vga_mode_ctrl_pkg.sv | 23 ++
 rtl/vga_mode_ctrl_if.sv | 9 +
 rtl/vga_mode_ctrl.sv | 94 +++++++++
 tb/tb_vga_mode_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mode_ctrl_pkg.sv
// Shared types and constants for the VGA mode sequencer and its benches.
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  localparam logic MODE_640X480     = 1'b0;
  localparam logic MODE_1440X900_D4 = 1'b1;

  localparam int unsigned FRAME_CLKS_640X480     = 420000;
  localparam int unsigned FRAME_CLKS_1440X900_D4 = 443632;

  // Settle counter must hold 0..SETTLE_FRAMES-1 but never be zero-width.
  function automatic int unsigned settle_cnt_width(input int unsigned frames);
    int unsigned w;
    w = $clog2(frames + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// Mode-change request handshake between the host/config logic and the sequencer.
interface vga_mode_ctrl_if;
  logic i_req_mode;
  logic i_req_valid;
  logic o_req_ready;

  modport master (output i_req_mode, output i_req_valid, input o_req_ready);
  modport slave  (input i_req_mode, input i_req_valid, output o_req_ready);
endinterface

// File: rtl/vga_mode_ctrl.sv
// Owns the timing generator's mode select: applies changes at frame wrap,
// force-blanks for a number of settle frames, and emits frame/line strobes.
module vga_mode_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned FRAME_CNT_W   = 8,
  parameter logic        MODE_RESET    = MODE_640X480
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vga_mode_ctrl_if.slave         req,
  input  logic                   i_hmax,
  input  logic                   i_vmax,
  output logic                   o_mode,
  output logic                   o_blank_force,
  output logic                   o_busy,
  output logic                   o_frame_start,
  output logic                   o_line_start,
  output logic [FRAME_CNT_W-1:0] o_frame_count
);

  localparam int unsigned SC_W = settle_cnt_width(SETTLE_FRAMES);
  localparam logic [SC_W-1:0] SETTLE_INIT =
    SC_W'((SETTLE_FRAMES == 0) ? 0 : SETTLE_FRAMES - 1);

  state_t          state, state_n;
  logic            pend_mode;
  logic [SC_W-1:0] settle_cnt;
  logic            frame_end;
  logic            latch_req;
  logic            apply;

  assign frame_end       = i_hmax & i_vmax;
  assign req.o_req_ready = (state == IDLE);
  assign o_busy          = (state != IDLE);

  always_comb begin
    state_n   = state;
    latch_req = 1'b0;
    apply     = 1'b0;
    unique case (state)
      IDLE: begin
        // Same-mode requests are consumed without leaving IDLE.
        if (req.i_req_valid && (req.i_req_mode != o_mode)) begin
          latch_req = 1'b1;
          state_n   = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          apply   = 1'b1;
          state_n = (SETTLE_FRAMES == 0) ? IDLE : SETTLE;
        end
      end
      SETTLE: begin
        if (frame_end && (settle_cnt == '0)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_mode     <= MODE_RESET;
      o_mode        <= MODE_RESET;
      settle_cnt    <= '0;
      o_blank_force <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_line_start  <= i_hmax;
      o_frame_start <= frame_end;
      o_blank_force <= (state_n == SETTLE);
      if (latch_req) pend_mode <= req.i_req_mode;
      if (apply) begin
        o_mode        <= pend_mode;
        o_frame_count <= '0;
        settle_cnt    <= SETTLE_INIT;
      end else begin
        if (frame_end) o_frame_count <= o_frame_count + 1'b1;
        if ((state == SETTLE) && frame_end && (settle_cnt != '0))
          settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl driven by a miniature 8x4 timing generator.
module tb_vga_mode_ctrl;
  import vga_ctrl_pkg::*;

  localparam int unsigned FRAME = 32;
  localparam int unsigned SF0   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] hpos = 3'd0;
  logic [1:0] vpos = 2'd0;
  logic hmax, vmax, fe;
  assign hmax = (hpos == 3'd7);
  assign vmax = (vpos == 2'd3);
  assign fe   = hmax & vmax;
  always @(posedge clk) begin
    hpos <= hpos + 3'd1;
    if (hpos == 3'd7) vpos <= vpos + 2'd1;
  end

  vga_mode_ctrl_if rif0 ();
  vga_mode_ctrl_if rif1 ();

  logic       mode0, blank0, busy0, fs0, ls0;
  logic [7:0] fc0;
  logic       mode1, blank1, busy1, fs1, ls1;
  logic [2:0] fc1;

  vga_mode_ctrl #(.SETTLE_FRAMES(SF0), .FRAME_CNT_W(8), .MODE_RESET(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(rif0), .i_hmax(hmax), .i_vmax(vmax),
    .o_mode(mode0), .o_blank_force(blank0), .o_busy(busy0),
    .o_frame_start(fs0), .o_line_start(ls0), .o_frame_count(fc0));

  vga_mode_ctrl #(.SETTLE_FRAMES(0), .FRAME_CNT_W(3), .MODE_RESET(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(rif1), .i_hmax(hmax), .i_vmax(vmax),
    .o_mode(mode1), .o_blank_force(blank1), .o_busy(busy1),
    .o_frame_start(fs1), .o_line_start(ls1), .o_frame_count(fc1));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe scoreboard: expectation pushed at each edge, compared mid-cycle.
  typedef struct packed { logic line; logic frame; } strobe_t;
  strobe_t sq[$];
  always @(posedge clk) if (reset_n) sq.push_back(strobe_t'{line: hmax, frame: fe});
  always @(negedge clk) begin
    strobe_t e;
    if (!reset_n) sq.delete();
    else if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("line_start0", 32'(ls0), 32'(e.line));
      chk("frame_start0", 32'(fs0), 32'(e.frame));
      chk("line_start1", 32'(ls1), 32'(e.line));
      chk("frame_start1", 32'(fs1), 32'(e.frame));
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the next frame_end edge; n counts edges consumed.
  task automatic wait_fe(output int unsigned n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (fe) ok = 1'b1;
      @(posedge clk);
      n++;
    end
    #1;
    if (!ok) chk("frame_end_timeout", 32'(0), 32'(1));
  endtask

  typedef struct {
    logic req_mode;
    bit   at_fe;
    bit   exp_busy;
    logic exp_mode;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int unsigned n, cyc;
    logic cur_mode, old;
    bit found;

    rif0.i_req_valid = 1'b0; rif0.i_req_mode = 1'b0;
    rif1.i_req_valid = 1'b0; rif1.i_req_mode = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values
    #27;
    chk("rst_mode", 32'(mode0), 32'(0));
    chk("rst_blank", 32'(blank0), 32'(0));
    chk("rst_busy", 32'(busy0), 32'(0));
    chk("rst_ready", 32'(rif0.o_req_ready), 32'(1));
    chk("rst_count", 32'(fc0), 32'(0));
    chk("rst_strobes", 32'({fs0, ls0}), 32'(0));
    reset_n = 1'b1;

    // Free-running frames; dut1's 3-bit counter must wrap
    for (int k = 1; k <= 10; k++) begin
      wait_fe(n);
      chk("count0", 32'(fc0), 32'(k));
      chk("count1_wrap", 32'(fc1), 32'(k % 8));
      chk("frame_start_at_wrap", 32'(fs0), 32'(1));
      chk("mode_idle", 32'(mode0), 32'(0));
    end

    cur_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      old = cur_mode;
      if (tbl[i].at_fe) begin
        found = 1'b0;
        for (int j = 0; j < 100 && !found; j++) begin
          @(negedge clk);
          if (fe) found = 1'b1;
        end
        if (!found) chk("align_timeout", 32'(0), 32'(1));
        rif0.i_req_mode = tbl[i].req_mode; rif0.i_req_valid = 1'b1;
        @(posedge clk); #1;
      end else begin
        wait_fe(n);
        tick(5);
        rif0.i_req_mode = tbl[i].req_mode; rif0.i_req_valid = 1'b1;
        tick(1);
      end
      rif0.i_req_valid = 1'b0;
      chk("ready_after_accept", 32'(rif0.o_req_ready), 32'(!tbl[i].exp_busy));
      chk("busy_after_accept", 32'(busy0), 32'(tbl[i].exp_busy));
      chk("mode_before_apply", 32'(mode0), 32'(old));
      if (tbl[i].exp_busy) begin
        wait_fe(n);
        if (tbl[i].at_fe) chk("old_frame_len", 32'(n), 32'(FRAME));
        chk("mode_applied", 32'(mode0), 32'(tbl[i].exp_mode));
        chk("count_restart", 32'(fc0), 32'(0));
        chk("blank_on_apply", 32'(blank0), 32'(1));
        for (int f = 1; f <= SF0; f++) begin
          tick(10);
          chk("blank_mid_settle", 32'(blank0), 32'(1));
          chk("ready_mid_settle", 32'(rif0.o_req_ready), 32'(0));
          wait_fe(n);
          chk("settle_count", 32'(fc0), 32'(f));
          chk("blank_settle", 32'(blank0), 32'(f < SF0));
          chk("busy_settle", 32'(busy0), 32'(f < SF0));
        end
      end else begin
        tick(3);
        chk("noop_blank", 32'(blank0), 32'(0));
        chk("noop_mode", 32'(mode0), 32'(old));
      end
      cur_mode = tbl[i].exp_mode;
    end

    // Second request held through SETTLE
    wait_fe(n);
    tick(3);
    rif0.i_req_mode = 1'b1; rif0.i_req_valid = 1'b1;
    tick(1);
    rif0.i_req_mode = 1'b0;
    wait_fe(n);
    chk("held_first_apply", 32'(mode0), 32'(1));
    cyc = 0;
    found = 1'b0;
    for (int j = 0; j < 300 && !found; j++) begin
      tick(1);
      cyc++;
      if (rif0.o_req_ready) found = 1'b1;
    end
    chk("held_settle_len", 32'(cyc), 32'(SF0 * FRAME));
    chk("held_blank_off", 32'(blank0), 32'(0));
    tick(1);
    rif0.i_req_valid = 1'b0;
    chk("held_accepted", 32'(busy0), 32'(1));
    chk("held_mode_kept", 32'(mode0), 32'(1));
    wait_fe(n);
    chk("held_apply_len", 32'(n), 32'(FRAME - 1));
    chk("held_second_apply", 32'(mode0), 32'(0));
    wait_fe(n);
    wait_fe(n);
    chk("held_done", 32'(busy0), 32'(0));

    // Asynchronous reset in the middle of SETTLE
    wait_fe(n);
    tick(2);
    rif0.i_req_mode = 1'b1; rif0.i_req_valid = 1'b1;
    tick(1);
    rif0.i_req_valid = 1'b0;
    wait_fe(n);
    tick(10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode0), 32'(0));
    chk("arst_blank", 32'(blank0), 32'(0));
    chk("arst_busy", 32'(busy0), 32'(0));
    chk("arst_ready", 32'(rif0.o_req_ready), 32'(1));
    chk("arst_count", 32'(fc0), 32'(0));
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick(1);
    chk("post_rst_mode", 32'(mode0), 32'(0));
    chk("post_rst_blank", 32'(blank0), 32'(0));
    chk("post_rst_busy", 32'(busy0), 32'(0));

    // Zero settle frames: switch without blanking
    wait_fe(n);
    tick(4);
    rif1.i_req_mode = 1'b1; rif1.i_req_valid = 1'b1;
    tick(1);
    rif1.i_req_valid = 1'b0;
    chk("sf0_ready", 32'(rif1.o_req_ready), 32'(0));
    chk("sf0_busy", 32'(busy1), 32'(1));
    chk("sf0_mode_hold", 32'(mode1), 32'(0));
    wait_fe(n);
    chk("sf0_mode", 32'(mode1), 32'(1));
    chk("sf0_blank", 32'(blank1), 32'(0));
    chk("sf0_idle", 32'(busy1), 32'(0));
    chk("sf0_ready_back", 32'(rif1.o_req_ready), 32'(1));
    chk("sf0_count", 32'(fc1), 32'(0));
    tick(5);
    chk("sf0_blank_later", 32'(blank1), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
